// File: rtl/player_input_map.sv
// Maps PS/2 keys and joystick bits onto per-player button vectors, with coin
// pulse stretching and a shared autofire phase.
module player_input_map #(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned NUM_BUTTONS  = 11,
  parameter logic [NUM_PLAYERS*NUM_BUTTONS*8-1:0] KEYMAP = '0,
  parameter int unsigned COIN_BIT     = 8,
  parameter int unsigned PAUSE_BIT    = 9,
  parameter int unsigned COIN_HOLD    = 16,
  parameter int unsigned AUTOFIRE_DIV = 1024
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [10:0]                        ps2_key,
  input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] joystick,
  input  logic [NUM_BUTTONS-1:0]             autofire_mask,
  output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] player,
  output logic                               pause
);

  localparam int unsigned NB = NUM_PLAYERS * NUM_BUTTONS;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_HOLD);
  localparam logic [CW-1:0] AF_LAST   = CW'(AUTOFIRE_DIV - 1);

  logic                          tog_q, tog_d;
  logic                          primed_q, primed_d;
  logic [NB-1:0]                 key_q, key_d;
  logic [NUM_PLAYERS-1:0][CW-1:0] coin_cnt_q, coin_cnt_d;
  logic [NUM_PLAYERS-1:0]        coin_prev_q, coin_prev_d;
  logic [CW-1:0]                 af_cnt_q, af_cnt_d;
  logic                          phase_q, phase_d;
  logic [NB-1:0]                 player_q, player_d;
  logic                          pause_q, pause_d;
  logic                          key_event;
  logic [NB-1:0]                 raw;
  logic                          unused_ext;

  // The extended-code flag carries no meaning for this mapping.
  assign unused_ext = ps2_key[8];

  // Key event detection and key-state update; the first edge after reset only primes.
  always_comb begin
    tog_d     = ps2_key[10];
    primed_d  = 1'b1;
    key_d     = key_q;
    key_event = primed_q && (ps2_key[10] != tog_q);
    if (key_event) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if ((KEYMAP[i*8 +: 8] != 8'h00) && (KEYMAP[i*8 +: 8] == ps2_key[7:0])) begin
          key_d[i] = ps2_key[9];
        end
      end
    end
  end

  assign raw = key_q | joystick;

  // Free-running autofire divider; phase flips each time the counter wraps.
  always_comb begin
    af_cnt_d = af_cnt_q + CW'(1);
    phase_d  = phase_q;
    if (af_cnt_q == AF_LAST) begin
      af_cnt_d = '0;
      phase_d  = ~phase_q;
    end
  end

  // Per-player coin stretcher; rising edges are ignored while a pulse is running.
  always_comb begin
    coin_cnt_d  = coin_cnt_q;
    coin_prev_d = coin_prev_q;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      coin_prev_d[p] = raw[p*NUM_BUTTONS + COIN_BIT];
      if (raw[p*NUM_BUTTONS + COIN_BIT] && !coin_prev_q[p] && (coin_cnt_q[p] == '0)) begin
        coin_cnt_d[p] = COIN_LOAD;
      end else if (coin_cnt_q[p] != '0) begin
        coin_cnt_d[p] = coin_cnt_q[p] - CW'(1);
      end
    end
  end

  // Output conditioning: coin from the stretcher, autofire gating elsewhere, pause OR.
  always_comb begin
    player_d = raw;
    pause_d  = 1'b0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      pause_d = pause_d | raw[p*NUM_BUTTONS + PAUSE_BIT];
      for (int unsigned b = 0; b < NUM_BUTTONS; b++) begin
        if (b == COIN_BIT) begin
          player_d[p*NUM_BUTTONS + b] = (coin_cnt_d[p] != '0);
        end else if (autofire_mask[b]) begin
          player_d[p*NUM_BUTTONS + b] = raw[p*NUM_BUTTONS + b] & phase_q;
        end
      end
    end
  end

  // State registers; phase comes out of reset high so autofire starts with a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tog_q       <= 1'b0;
      primed_q    <= 1'b0;
      key_q       <= '0;
      coin_cnt_q  <= '0;
      coin_prev_q <= '0;
      af_cnt_q    <= '0;
      phase_q     <= 1'b1;
      player_q    <= '0;
      pause_q     <= 1'b0;
    end else begin
      tog_q       <= tog_d;
      primed_q    <= primed_d;
      key_q       <= key_d;
      coin_cnt_q  <= coin_cnt_d;
      coin_prev_q <= coin_prev_d;
      af_cnt_q    <= af_cnt_d;
      phase_q     <= phase_d;
      player_q    <= player_d;
      pause_q     <= pause_d;
    end
  end

  assign player = player_q;
  assign pause  = pause_q;

endmodule

// File: tb/tb_player_input_map.sv
// Directed bench for player_input_map: expected outputs are queued with the
// cycle they are due on, and a negedge monitor pops and compares them.
module tb_player_input_map;

  localparam int unsigned NP = 4;
  localparam int unsigned NB = 11;
  localparam int unsigned W  = NP * NB;
  localparam int unsigned KW = W * 8;
  // Entry 0 = 0x75; entries 12 and 23 both = 0x72; everything else unmapped.
  localparam logic [KW-1:0] KM = KW'(8'h75) | (KW'(8'h72) << (12*8)) | (KW'(8'h72) << (23*8));

  logic          clock = 1'b0;
  logic          reset;
  logic [10:0]   ps2_key;
  logic [W-1:0]  joystick;
  logic [NB-1:0] autofire_mask;
  logic [W-1:0]  player;
  logic          pause;

  player_input_map #(
    .NUM_PLAYERS(NP), .NUM_BUTTONS(NB), .KEYMAP(KM),
    .COIN_BIT(8), .PAUSE_BIT(9), .COIN_HOLD(16), .AUTOFIRE_DIV(4)
  ) dut (
    .clock(clock), .reset(reset), .ps2_key(ps2_key), .joystick(joystick),
    .autofire_mask(autofire_mask), .player(player), .pause(pause)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int unsigned  cyc;
    logic [W-1:0] pl;
    logic         pa;
  } exp_t;

  exp_t        exp_q[$];
  string       nm_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        stim_done = 1'b0;
  int unsigned deadline  = 0;
  exp_t        e;
  string       nm;
  logic        tog;
  int unsigned c0;

  task automatic expect_at(input int unsigned c, input string name,
                           input logic [W-1:0] pl, input logic pa);
    exp_t x;
    x.cyc = c; x.pl = pl; x.pa = pa;
    exp_q.push_back(x);
    nm_q.push_back(name);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic key(input logic pressed, input logic [7:0] code);
    tog     = ~tog;
    ps2_key = {tog, pressed, 1'b0, code};
  endtask

  function automatic logic [W-1:0] bv(input int unsigned i);
    logic [W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Monitor: compare every expectation due on this cycle.
  always @(negedge clock) begin
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_checks = n_checks + 1;
      if (e.cyc != cyc) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: due cycle %0d, checked at %0d", nm, e.cyc, cyc);
      end else if (player !== e.pl || pause !== e.pa) begin
        n_fail = n_fail + 1;
        $display("FAIL %s @%0d: player=%h pause=%b, required player=%h pause=%b",
                 nm, cyc, player, pause, e.pl, e.pa);
      end
    end
    if (stim_done && cyc > deadline && exp_q.size() != 0) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
      exp_q.delete();
      nm_q.delete();
    end
  end

  initial begin
    reset         = 1'b1;
    tog           = 1'b1;
    ps2_key       = {1'b1, 1'b1, 1'b0, 8'h75};
    joystick      = '0;
    autofire_mask = '0;
    tick(3);
    expect_at(cyc, "reset_state", '0, 1'b0);
    tick(1);

    // Toggle bit steady high (with a mapped press) through reset release: no event.
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) expect_at(cyc + k, "prime_no_event", '0, 1'b0);
    tick(6);

    // Key press/release with two-clock latency.
    key(1'b1, 8'h75);
    expect_at(cyc + 1, "key_lat1", '0, 1'b0);
    expect_at(cyc + 2, "key_press", bv(0), 1'b0);
    tick(4);
    key(1'b0, 8'h75);
    expect_at(cyc + 1, "key_hold", bv(0), 1'b0);
    expect_at(cyc + 2, "key_release", '0, 1'b0);
    tick(4);

    // Duplicate keymap entries both follow the key.
    key(1'b1, 8'h72);
    expect_at(cyc + 2, "dup_press", bv(12) | bv(23), 1'b0);
    tick(4);
    key(1'b0, 8'h72);
    expect_at(cyc + 2, "dup_release", '0, 1'b0);
    tick(4);

    // Scancode 0x00 never matches unmapped entries.
    key(1'b1, 8'h00);
    expect_at(cyc + 2, "code00_a", '0, 1'b0);
    expect_at(cyc + 3, "code00_b", '0, 1'b0);
    tick(5);

    // Joystick path has one-clock latency.
    joystick = bv(3);
    expect_at(cyc, "joy_before", '0, 1'b0);
    expect_at(cyc + 1, "joy_lat1", bv(3), 1'b0);
    tick(3);
    joystick = '0;
    expect_at(cyc + 1, "joy_clear", '0, 1'b0);
    tick(3);

    // Player 3 pause bit drives the pause output and only player 3's vector.
    joystick = bv(3*NB + 9);
    expect_at(cyc, "pause_before", '0, 1'b0);
    expect_at(cyc + 1, "pause_p3", bv(3*NB + 9), 1'b1);
    tick(3);
    joystick = '0;
    expect_at(cyc + 1, "pause_clear", '0, 1'b0);
    tick(3);

    // Key release and joystick press on the same bit in the same cycle.
    key(1'b1, 8'h75);
    expect_at(cyc + 2, "overlap_key", bv(0), 1'b0);
    tick(3);
    joystick = bv(0);
    key(1'b0, 8'h75);
    for (int k = 1; k <= 3; k++) expect_at(cyc + k, "overlap_or", bv(0), 1'b0);
    tick(4);
    joystick = '0;
    expect_at(cyc + 1, "overlap_release", '0, 1'b0);
    tick(3);

    // Coin held 100 clocks gives one 16-clock pulse; autofire mask on coin is inert.
    autofire_mask = 11'h100;
    joystick      = bv(8);
    c0            = cyc;
    expect_at(c0, "coin_before", '0, 1'b0);
    for (int k = 1; k <= 100; k++)
      expect_at(c0 + k, (k <= 16) ? "coin_pulse" : "coin_after",
                (k <= 16) ? bv(8) : '0, 1'b0);
    tick(100);
    joystick = '0;
    tick(5);
    joystick = bv(8);
    c0       = cyc;
    for (int k = 1; k <= 20; k++)
      expect_at(c0 + k, (k <= 16) ? "coin2_pulse" : "coin2_after",
                (k <= 16) ? bv(8) : '0, 1'b0);
    tick(20);
    joystick      = '0;
    autofire_mask = '0;
    tick(3);

    // Held key, one-clock reset pulse: everything clears and the key stays released.
    key(1'b1, 8'h75);
    expect_at(cyc + 2, "held_key", bv(0), 1'b0);
    tick(4);
    reset = 1'b1;
    expect_at(cyc, "reset_pulse", '0, 1'b0);
    tick(1);
    reset         = 1'b0;
    joystick      = bv(4);
    autofire_mask = 11'h010;
    c0            = cyc;
    expect_at(c0, "post_reset", '0, 1'b0);
    // Autofire from a fresh reset: 4 high, 4 low, 4 high; bit 0 must stay low.
    for (int k = 1; k <= 12; k++)
      expect_at(c0 + k, "autofire", ((((k - 1) / 4) % 2) == 0) ? bv(4) : '0, 1'b0);
    tick(12);
    // Dropping the mask passes the raw bit through on the next clock.
    autofire_mask = '0;
    expect_at(cyc + 1, "mask_off_a", bv(4), 1'b0);
    expect_at(cyc + 2, "mask_off_b", bv(4), 1'b0);
    tick(3);
    joystick = '0;
    expect_at(cyc + 1, "final_clear", '0, 1'b0);
    tick(2);

    deadline  = cyc + 50;
    stim_done = 1'b1;
    repeat (60) begin
      if (exp_q.size() == 0) break;
      tick(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
